// File: rtl/rx_channel.sv
// rx_channel: XSerial receive deserialiser for one router port.
// Deframes 15-bit LSB-first frames and checks parity. Data frames are forwarded
// with a one-cycle valid. HALT/RESUME messages drive the 'halted' level.
module rx_channel #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_serial,
   output logic [11:0]      rx_data,
   output logic             rx_valid,
   output logic             halted,
   output logic             parity_err,
   output logic             frame_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned BIT_W    = 4;
   localparam int unsigned DATA_W   = 12;
   localparam int unsigned LAST_BIT = DATA_W - 1;

   typedef enum logic [2:0] {
      HUNT   = 3'd0,
      IDLE   = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t              state;
   logic [BIT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic                parity_ok;

   logic                eval_ok;
   logic                good_data;
   logic                halt_msg;
   logic                resume_msg;
   logic                frame_inc;
   logic                err_inc;

   // Frame classification on the cycle whose edge samples the stop bit
   always_comb begin
      eval_ok    = (state == STOP) && in_serial;
      good_data  = eval_ok && parity_ok && (shreg[3:2] == 2'b00);
      halt_msg   = eval_ok && parity_ok && (shreg[3:2] == 2'b01) && (shreg[11:4] == 8'h01);
      resume_msg = eval_ok && parity_ok && (shreg[3:2] == 2'b01) && (shreg[11:4] == 8'h02);
      frame_inc  = good_data || halt_msg || resume_msg;
      err_inc    = ((state == STOP) && !in_serial) ||
                   (eval_ok && !parity_ok) ||
                   (eval_ok && parity_ok && shreg[3]);
   end

   // Deframing FSM with registered frame outputs; pulses default low each cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= HUNT;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity_ok  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         halted     <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            HUNT: begin
               if (in_serial) state <= IDLE;
            end
            IDLE: begin
               if (!in_serial) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               shreg   <= {in_serial, shreg[DATA_W-1:1]};
               bit_cnt <= BIT_W'(bit_cnt + 1'b1);
               if (bit_cnt == BIT_W'(LAST_BIT)) state <= PARITY;
            end
            PARITY: begin
               parity_ok <= (in_serial == ^shreg);
               state     <= STOP;
            end
            STOP: begin
               if (in_serial) begin
                  state <= IDLE;
                  if (!parity_ok) parity_err <= 1'b1;
                  if (good_data) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end
                  if (halt_msg)   halted <= 1'b1;
                  if (resume_msg) halted <= 1'b0;
               end else begin
                  frame_err <= 1'b1;
                  state     <= HUNT;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   // Saturating statistics counters; clear overrides increment
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (cnt_clr) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_inc && (frame_cnt != '1)) frame_cnt <= frame_cnt + CNT_W'(1);
         if (err_inc && (err_cnt != '1))     err_cnt   <= err_cnt + CNT_W'(1);
      end
   end

endmodule
